// File: rtl/vdp_cpu_bus_if.sv
// Host-CPU bus front end for the V9958: synchronises and filters the CPU strobes,
// queues accesses in order and issues them to the VDP as REQ/ACK transactions.
module vdp_cpu_bus_if #(
    parameter int FILTER_LEN = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       csw_n,
    input  logic       csr_n,
    input  logic [1:0] mode,
    input  logic [7:0] cd_in,
    output logic [7:0] cd_out,
    output logic       cd_oe,
    output logic       vdp_req,
    output logic       vdp_wrt,
    output logic [1:0] vdp_adr,
    output logic [7:0] vdp_dbo,
    input  logic       vdp_ack,
    input  logic [7:0] vdp_dbi,
    output logic       busy,
    output logic       overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [3:0]  FLT_LAST = 4'(FILTER_LEN - 1);
    localparam logic [AW:0] CNT_FULL = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW:0] CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_GAP} state_t;

    logic       r_csw_s1, r_csw_s2, r_csr_s1, r_csr_s2;
    logic [1:0] r_mode_s1, r_mode_s2;
    logic [7:0] r_cd_s1, r_cd_s2;

    logic       r_csw_f, r_csr_f, r_csw_fd, r_csr_fd;
    logic [3:0] r_csw_cnt, r_csr_cnt;

    logic [10:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wp, r_rp;
    logic [AW:0]   r_cnt;
    logic          r_ovf;

    state_t     r_state, w_state_nx;
    logic       r_wrt;
    logic [1:0] r_adr;
    logic [7:0] r_dbo, r_rdata;

    logic        w_csw_fall, w_csr_fall, w_push_wr, w_push_rd, w_push, w_push_ok;
    logic        w_empty, w_full, w_load, w_pop;
    logic [10:0] w_entry, w_head;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_csw_s1  <= 1'b1;
            r_csw_s2  <= 1'b1;
            r_csr_s1  <= 1'b1;
            r_csr_s2  <= 1'b1;
            r_mode_s1 <= '0;
            r_mode_s2 <= '0;
            r_cd_s1   <= '0;
            r_cd_s2   <= '0;
        end else begin
            r_csw_s1  <= csw_n;
            r_csw_s2  <= r_csw_s1;
            r_csr_s1  <= csr_n;
            r_csr_s2  <= r_csr_s1;
            r_mode_s1 <= mode;
            r_mode_s2 <= r_mode_s1;
            r_cd_s1   <= cd_in;
            r_cd_s2   <= r_cd_s1;
        end
    end

    // Filtered level flips only after FILTER_LEN consecutive disagreeing samples.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_csw_f   <= 1'b1;
            r_csw_cnt <= '0;
        end else if (r_csw_s2 == r_csw_f) begin
            r_csw_cnt <= '0;
        end else if (r_csw_cnt == FLT_LAST) begin
            r_csw_f   <= r_csw_s2;
            r_csw_cnt <= '0;
        end else begin
            r_csw_cnt <= r_csw_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_csr_f   <= 1'b1;
            r_csr_cnt <= '0;
        end else if (r_csr_s2 == r_csr_f) begin
            r_csr_cnt <= '0;
        end else if (r_csr_cnt == FLT_LAST) begin
            r_csr_f   <= r_csr_s2;
            r_csr_cnt <= '0;
        end else begin
            r_csr_cnt <= r_csr_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_csw_fd <= 1'b1;
            r_csr_fd <= 1'b1;
        end else begin
            r_csw_fd <= r_csw_f;
            r_csr_fd <= r_csr_f;
        end
    end

    // A fall only counts while the other strobe is idle; simultaneous falls cancel out.
    assign w_csw_fall = r_csw_fd & ~r_csw_f;
    assign w_csr_fall = r_csr_fd & ~r_csr_f;
    assign w_push_wr  = w_csw_fall & r_csr_f;
    assign w_push_rd  = w_csr_fall & r_csw_f;
    assign w_push     = w_push_wr | w_push_rd;
    assign w_entry    = {w_push_rd, r_mode_s2, (w_push_rd ? 8'h00 : r_cd_s2)};

    assign w_empty   = (r_cnt == '0);
    assign w_full    = (r_cnt == CNT_FULL);
    assign w_push_ok = w_push & ~w_full;
    assign w_head    = r_mem[r_rp];

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wp] <= w_entry;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else begin
            if (w_push_ok) r_wp <= r_wp + PTR_ONE;
            if (w_pop)     r_rp <= r_rp + PTR_ONE;
            if (w_push & w_full) r_ovf <= 1'b1;
            unique case ({w_push_ok, w_pop})
                2'b10:   r_cnt <= r_cnt + CNT_ONE;
                2'b01:   r_cnt <= r_cnt - CNT_ONE;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_nx;
    end

    // The head stays queued during REQ; it is popped only on ack.
    always_comb begin
        w_state_nx = r_state;
        w_load     = 1'b0;
        w_pop      = 1'b0;
        unique case (r_state)
            S_IDLE: if (!w_empty) begin
                w_load     = 1'b1;
                w_state_nx = S_REQ;
            end
            S_REQ: if (vdp_ack) begin
                w_pop      = 1'b1;
                w_state_nx = S_GAP;
            end
            S_GAP:   w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wrt   <= 1'b0;
            r_adr   <= '0;
            r_dbo   <= '0;
            r_rdata <= '0;
        end else if (w_load) begin
            r_wrt <= ~w_head[10];
            r_adr <= w_head[9:8];
            r_dbo <= w_head[7:0];
            if (w_head[10]) r_rdata <= vdp_dbi;
        end
    end

    assign vdp_req  = (r_state == S_REQ);
    assign vdp_wrt  = r_wrt;
    assign vdp_adr  = r_adr;
    assign vdp_dbo  = r_dbo;
    assign cd_out   = r_rdata;
    assign cd_oe    = ~r_csr_f;
    assign busy     = ~w_empty | (r_state != S_IDLE);
    assign overflow = r_ovf;

endmodule

// File: tb/tb_vdp_cpu_bus_if.sv
// Scoreboard bench for vdp_cpu_bus_if: directed latency/read/glitch/overflow/reset
// scenarios plus randomized CPU accesses against a transaction-level model.
module tb_vdp_cpu_bus_if;
    localparam int FL   = 4;
    localparam int FD   = 4;
    localparam int HOLD = FL + 6;

    logic       clk = 1'b0, reset_n = 1'b0, csw_n = 1'b1, csr_n = 1'b1;
    logic [1:0] mode = '0;
    logic [7:0] cd_in = '0, vdp_dbi = '0;
    logic       vdp_ack = 1'b0;
    logic [7:0] cd_out, vdp_dbo;
    logic [1:0] vdp_adr;
    logic       cd_oe, vdp_req, vdp_wrt, busy, overflow;

    vdp_cpu_bus_if #(.FILTER_LEN(FL), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .reset_n(reset_n), .csw_n(csw_n), .csr_n(csr_n), .mode(mode),
        .cd_in(cd_in), .cd_out(cd_out), .cd_oe(cd_oe), .vdp_req(vdp_req),
        .vdp_wrt(vdp_wrt), .vdp_adr(vdp_adr), .vdp_dbo(vdp_dbo), .vdp_ack(vdp_ack),
        .vdp_dbi(vdp_dbi), .busy(busy), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       wrt;
        logic [1:0] adr;
        logic [7:0] dbo;
    } txn_t;

    txn_t sb[$];
    txn_t cur;
    int   n_checks = 0, n_fail = 0;
    int   occ = 0;
    logic exp_ovf = 1'b0;
    bit   ack_en = 1'b1, mon_en = 1'b0, fixed_dly = 1'b0;
    int   ack_dly = 0, ack_cnt = 0;
    logic prev_req = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One CPU strobe cycle; the model accepts it only while the queue has room.
    task automatic cpu_access(input bit rd, input logic [1:0] m, input logic [7:0] d);
        txn_t t;
        mode  = m;
        cd_in = d;
        t.wrt = ~rd;
        t.adr = m;
        t.dbo = rd ? 8'h00 : d;
        if (occ < FD) begin
            sb.push_back(t);
            occ++;
        end else begin
            exp_ovf = 1'b1;
        end
        if (rd) csr_n = 1'b0;
        else    csw_n = 1'b0;
        tick(HOLD);
        csw_n = 1'b1;
        csr_n = 1'b1;
        tick(HOLD);
    endtask

    task automatic wait_idle(input string nm);
        int k = 0;
        while ((busy || sb.size() != 0) && k < 400) begin
            tick(1);
            k++;
        end
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_sb"}, sb.size(), 0);
    endtask

    // VDP responder: acks after a delay, then presents a fresh read-ahead byte.
    always begin
        @(posedge clk);
        #1;
        if (vdp_ack) begin
            vdp_ack = 1'b0;
            vdp_dbi = 8'($urandom);
            occ--;
            ack_cnt = 0;
            ack_dly = fixed_dly ? 3 : int'($urandom_range(0, 3));
        end else if (vdp_req && ack_en) begin
            if (ack_cnt >= ack_dly) vdp_ack = 1'b1;
            else ack_cnt++;
        end
    end

    // Monitor: each new request must match the oldest expected access.
    always @(negedge clk) begin
        if (mon_en && reset_n) begin
            if (vdp_req && !prev_req) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_req: got wrt=%0d adr=%0d dbo=%0h with empty queue",
                             vdp_wrt, vdp_adr, vdp_dbo);
                end else begin
                    cur = sb.pop_front();
                    chk("req_wrt", vdp_wrt, cur.wrt);
                    chk("req_adr", vdp_adr, cur.adr);
                    chk("req_dbo", vdp_dbo, cur.dbo);
                    if (!cur.wrt) chk("rd_cd_out", cd_out, vdp_dbi);
                end
            end else if (vdp_req) begin
                chk("req_hold", {vdp_wrt, vdp_adr, vdp_dbo}, cur);
            end
        end
        prev_req = vdp_req;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        n_fail++;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks + 1, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        int   lat, ack_i, fall_i, rise_i;
        logic bz [0:31];
        logic oe [0:31];
        logic saw_req, saw_busy;
        logic [7:0] rd_val;
        logic       rd_wrt;

        tick(3);
        chk("rst_req", vdp_req, 0);
        chk("rst_wrt", vdp_wrt, 0);
        chk("rst_adr", vdp_adr, 0);
        chk("rst_dbo", vdp_dbo, 0);
        chk("rst_cd_out", cd_out, 0);
        chk("rst_cd_oe", cd_oe, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovf", overflow, 0);
        reset_n = 1'b1;
        mon_en  = 1'b1;
        tick(2);

        // Directed write: latency, fields, ack-to-drop and busy timing.
        fixed_dly = 1'b1;
        ack_dly   = 3;
        ack_cnt   = 0;
        mode  = 2'd1;
        cd_in = 8'h87;
        sb.push_back(txn_t'{1'b1, 2'd1, 8'h87});
        occ++;
        csw_n = 1'b0;
        lat = 0; ack_i = 0; fall_i = 0;
        for (int i = 1; i <= 20; i++) begin
            tick(1);
            bz[i] = busy;
            if (vdp_req && lat == 0) begin
                lat = i;
                chk("wr_wrt", vdp_wrt, 1);
                chk("wr_adr", vdp_adr, 1);
                chk("wr_dbo", vdp_dbo, 8'h87);
            end
            if (vdp_ack && ack_i == 0) ack_i = i;
            if (lat != 0 && !vdp_req && fall_i == 0) fall_i = i;
        end
        chk("wr_latency", lat, FL + 4);
        chk("wr_drop_after_ack", fall_i, ack_i + 1);
        chk("wr_busy_gap", bz[ack_i + 1], 1);
        chk("wr_busy_idle", bz[ack_i + 2], 0);
        csw_n = 1'b1;
        fixed_dly = 1'b0;
        tick(HOLD);
        wait_idle("wr_done");

        // Directed read: cd_oe from filter acceptance, read-ahead on IDLE->REQ.
        vdp_dbi = 8'h5A;
        mode    = 2'd0;
        sb.push_back(txn_t'{1'b0, 2'd0, 8'h00});
        occ++;
        csr_n  = 1'b0;
        rise_i = 0;
        rd_val = '0;
        rd_wrt = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick(1);
            oe[i] = cd_oe;
            if (vdp_req && rise_i == 0) begin
                rise_i = i;
                rd_val = cd_out;
                rd_wrt = vdp_wrt;
            end
        end
        chk("rd_oe_before", oe[FL + 1], 0);
        chk("rd_oe_accept", oe[FL + 2], 1);
        chk("rd_latency", rise_i, FL + 4);
        chk("rd_data", rd_val, 8'h5A);
        chk("rd_wrt", rd_wrt, 0);
        csr_n = 1'b1;
        tick(HOLD);
        chk("rd_oe_release", cd_oe, 0);
        wait_idle("rd_done");

        // Glitch shorter than the filter.
        csw_n = 1'b0;
        tick(FL - 1);
        csw_n = 1'b1;
        saw_req = 1'b0;
        saw_busy = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick(1);
            saw_req  = saw_req | vdp_req;
            saw_busy = saw_busy | busy;
        end
        chk("glitch_req", saw_req, 0);
        chk("glitch_busy", saw_busy, 0);

        // Both strobes fall together: nothing queued.
        csw_n = 1'b0;
        csr_n = 1'b0;
        saw_req = 1'b0;
        saw_busy = 1'b0;
        for (int i = 0; i < 2 * HOLD; i++) begin
            tick(1);
            if (i == HOLD - 1) begin
                csw_n = 1'b1;
                csr_n = 1'b1;
            end
            saw_req  = saw_req | vdp_req;
            saw_busy = saw_busy | busy;
        end
        chk("both_req", saw_req, 0);
        chk("both_busy", saw_busy, 0);
        chk("both_ovf", overflow, exp_ovf);

        // Write strobe while read is already low: only the read is queued.
        mode = 2'd2;
        sb.push_back(txn_t'{1'b0, 2'd2, 8'h00});
        occ++;
        csr_n = 1'b0;
        tick(HOLD);
        cd_in = 8'hC3;
        csw_n = 1'b0;
        tick(HOLD);
        csw_n = 1'b1;
        tick(HOLD);
        csr_n = 1'b1;
        tick(HOLD);
        wait_idle("overlap");

        // Ordering and overflow with the VDP stalled.
        ack_en = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            cpu_access(1'b0, 2'(i), 8'(i));
            chk("ovf_step", overflow, exp_ovf);
        end
        chk("ovf_set", overflow, 1);
        ack_en = 1'b1;
        wait_idle("ovf_drain");
        chk("ovf_sticky", overflow, 1);

        // Randomized accesses.
        for (int n = 0; n < 24; n++)
            cpu_access(1'($urandom), 2'($urandom), 8'($urandom));
        wait_idle("rand");

        // Reset during REQ with two entries queued.
        ack_en = 1'b0;
        cpu_access(1'b0, 2'd3, 8'hA1);
        cpu_access(1'b0, 2'd2, 8'hB2);
        chk("rstmid_pre_req", vdp_req, 1);
        #2;
        mon_en  = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("rstmid_req", vdp_req, 0);
        chk("rstmid_wrt", vdp_wrt, 0);
        chk("rstmid_adr", vdp_adr, 0);
        chk("rstmid_dbo", vdp_dbo, 0);
        chk("rstmid_cd_out", cd_out, 0);
        chk("rstmid_cd_oe", cd_oe, 0);
        chk("rstmid_busy", busy, 0);
        chk("rstmid_ovf", overflow, 0);
        sb.delete();
        occ = 0;
        exp_ovf = 1'b0;
        tick(2);
        reset_n = 1'b1;
        ack_en  = 1'b1;
        mon_en  = 1'b1;
        saw_req = 1'b0;
        saw_busy = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick(1);
            saw_req  = saw_req | vdp_req;
            saw_busy = saw_busy | busy;
        end
        chk("rstmid_after_req", saw_req, 0);
        chk("rstmid_after_busy", saw_busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
